spawn_arbiter: RTL and testbench
================================

Name: spawn_arbiter

Overview:
- Shares one placement resource between two requesters: apple spawn (req 0) and barrier spawn (req 1).
- The resource is an LFSR cell-candidate generator plus a free-cell check against the combined occupancy grid.
- Sequences draw and check attempts, then falls back to a deterministic scan when random draws keep hitting occupied cells.
- Sits between the game-logic FSM and the grid-rendering logic. Replaces per-requester free-running draw loops.

Parameters:
- MAX_TRIES, 8, random draws per request before fallback (1..255).
- SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'hACE1.

Ports:
- clk_25M  input  1  system clock, 25 MHz.
- rst  input  1  reset, asynchronous, active-high.
- req  input  2  spawn requests; bit0 = apple, bit1 = barrier; level, held until ack.
- occ_grid  input  101  combined occupancy (head|body|apple|barrier); bit i = cell i; 1 = occupied.
- ack  output  2  one-cycle completion pulse per requester.
- cell_out  output  8  granted cell index, row*10+col, row 1..8, col 2..9.
- fail  output  1  pulses with ack when no free cell was found.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock, clk_25M. Reset is asynchronous and active-high.
- Reset values: ack=0, cell_out=0, fail=0, busy=0, FSM=IDLE, lfsr=SEED, last_grant=1 (apple wins the first contention), try_cnt=0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; steps every clock in every state (free-running).
- Candidate formation: row=lfsr[2:0]+1, col=lfsr[5:3]+2, cand=row*10+col. Computed in 8-bit unsigned arithmetic.
- IDLE:
  - If any req bit is set, latch owner and set try_cnt=0, then go to DRAW.
  - If both bits are set, owner = the requester not equal to last_grant.
- DRAW: register cand from the current lfsr; try_cnt++; go to CHECK.
- CHECK:
  - occ_grid[cand]==0 -> GRANT.
  - Else if try_cnt==MAX_TRIES -> SCAN (macro on) or FAIL (macro off).
  - Else -> DRAW.
- SCAN:
  - Examine one cell per cycle, starting at 12: col 2..9, then next row, through 89 (64 cells).
  - First free cell -> GRANT with that cell.
  - Cell 89 occupied -> FAIL.
- GRANT: ack[owner]=1 and cell_out=the granted cell, both registered; last_grant=owner; next state IDLE.
- FAIL: ack[owner]=1, fail=1, cell_out unchanged; last_grant=owner; next state IDLE.
- Output hold: ack and fail are high for exactly one cycle. cell_out holds its value until the next GRANT.
- Latency: if the first draw is free, ack is high 3 cycles after req is sampled in IDLE.
- Abort: if req[owner] falls while in DRAW, CHECK or SCAN, return to IDLE at the next edge with no ack. last_grant is unchanged.
- Same-cycle events:
  - A new request on the other bit while busy is ignored until IDLE.
  - In IDLE directly after GRANT, a still-pending other requester is served next.
- occ_grid is sampled combinationally in CHECK and SCAN only. The caller keeps it stable while busy.
- Out-of-range: indices outside the 8x8 region are never produced.
- Reset mid-operation: all state is cleared immediately and no ack is issued.

Optional Feature:
- Macro: SPAWN_SCAN_FALLBACK_EN.
- Defined: after MAX_TRIES occupied draws, the SCAN state is used; fail is asserted only when all 64 cells are occupied.
- Undefined: the SCAN state and scan counter are not built; CHECK goes straight to FAIL on exhaustion.

Decomposition:
- Shared package spawn_pkg:
  - State enum (IDLE, DRAW, CHECK, SCAN, GRANT, FAIL).
  - Constants: GRID_W=101, ROW_MIN=1, ROW_MAX=8, COL_MIN=2, COL_MAX=9, REQ_APPLE=0, REQ_BARRIER=1, LFSR_DEFAULT=16'hACE1.
- Natural sub-module: spawn_lfsr.
  - Contents: the 16-bit LFSR plus the cand mapping.
  - Interface: clk_25M, rst, SEED param; cand output.
  - Reusable by other randomised spawns.

Test Plan:
- Free grid, MAX_TRIES=8, req=01 at cycle 0 -> ack=01 at cycle 3, fail=0; cell_out row 1..8, col 2..9.
- Free grid, req=11 held -> first ack=01 (apple), next ack=10 (barrier); cell_out updates each time.
- All cells occupied except 57, MAX_TRIES=4, macro on -> 4 draws (CHECK cycles 2,4,6,8), SCAN from cycle 9, ack at cycle 47 with cell_out=57, fail=0.
- All 64 cells occupied, MAX_TRIES=4: macro on -> ack and fail at cycle 73; macro off -> ack and fail at cycle 9; cell_out unchanged in both cases.
- req=10 dropped during SCAN -> no ack, busy=0 next cycle; a following req=10 restarts with try_cnt=0.
- rst pulsed mid-DRAW -> ack=0, busy=0, lfsr=SEED immediately; SEED=0 build -> lfsr resets to 16'hACE1.

Source files
------------

// File: rtl/spawn_pkg.sv
// spawn_pkg: shared states, grid geometry and the cell-index mapping used by the spawn arbiter
// and by any other randomised placement logic.
package spawn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAW,
        CHECK,
        SCAN,
        GRANT,
        FAIL
    } state_e;

    localparam int          GRID_W       = 101;
    localparam int          ROW_MIN      = 1;
    localparam int          ROW_MAX      = 8;
    localparam int          COL_MIN      = 2;
    localparam int          COL_MAX      = 9;
    localparam int          REQ_APPLE    = 0;
    localparam int          REQ_BARRIER  = 1;
    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

    // Offsets are 0..7, so the result is always inside the 8x8 playfield (12..89).
    function automatic logic [7:0] cell_of(input logic [2:0] row_off, input logic [2:0] col_off);
        logic [7:0] row;
        logic [7:0] col;
        row = {5'd0, row_off} + 8'(ROW_MIN);
        col = {5'd0, col_off} + 8'(COL_MIN);
        return row * 8'd10 + col;
    endfunction

endpackage

// File: rtl/spawn_lfsr.sv
// spawn_lfsr: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) and its mapping onto
// a playfield cell candidate.
module spawn_lfsr
    import spawn_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT
) (
    input  logic       clk_25M,
    input  logic       rst,
    output logic [7:0] cand
);

    // An all-zero state would lock the LFSR, so a zero seed falls back to the default.
    localparam logic [15:0] RST_VAL = (SEED == 16'd0) ? LFSR_DEFAULT : SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        feedback;

    assign feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign lfsr_d   = {lfsr_q[14:0], feedback};

    always_ff @(posedge clk_25M or posedge rst) begin
        if (rst) begin
            lfsr_q <= RST_VAL;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign cand = cell_of(lfsr_q[2:0], lfsr_q[5:3]);

endmodule

// File: rtl/spawn_arbiter.sv
// spawn_arbiter: shares one random placement engine between apple (req 0) and barrier (req 1).
// Build option SPAWN_SCAN_FALLBACK_EN adds a 64-cell deterministic scan after MAX_TRIES misses.
module spawn_arbiter
    import spawn_pkg::*;
#(
    parameter int          MAX_TRIES = 8,
    parameter logic [15:0] SEED      = LFSR_DEFAULT
) (
    input  logic              clk_25M,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [GRID_W-1:0] occ_grid,
    output logic [1:0]        ack,
    output logic [7:0]        cell_out,
    output logic              fail,
    output logic              busy
);

    state_e     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_grant_q, last_grant_d;
    logic [7:0] try_cnt_q, try_cnt_d;
    logic [7:0] cand_q, cand_d;
    logic [7:0] cell_q, cell_d;
    logic [1:0] ack_q, ack_d;
    logic       fail_q, fail_d;
    logic [7:0] lfsr_cand;
    logic [1:0] owner_onehot;
    logic       abort;

    spawn_lfsr #(.SEED(SEED)) u_lfsr (
        .clk_25M (clk_25M),
        .rst     (rst),
        .cand    (lfsr_cand)
    );

    assign owner_onehot = owner_q ? 2'b10 : 2'b01;
    assign abort        = !req[owner_q];

`ifdef SPAWN_SCAN_FALLBACK_EN
    logic [5:0] scan_idx_q, scan_idx_d;
    logic [7:0] scan_cell;

    // Index bits [2:0] walk the columns, so the scan runs row by row from 12 to 89.
    assign scan_cell = cell_of(scan_idx_q[5:3], scan_idx_q[2:0]);

    always_ff @(posedge clk_25M or posedge rst) begin
        if (rst) begin
            scan_idx_q <= '0;
        end else begin
            scan_idx_q <= scan_idx_d;
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        try_cnt_d    = try_cnt_q;
        cand_d       = cand_q;
        cell_d       = cell_q;
        ack_d        = 2'b00;
        fail_d       = 1'b0;
`ifdef SPAWN_SCAN_FALLBACK_EN
        scan_idx_d   = scan_idx_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d   = DRAW;
                    try_cnt_d = '0;
                    owner_d   = (&req) ? ~last_grant_q : req[REQ_BARRIER];
                end
            end
            DRAW: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    cand_d    = lfsr_cand;
                    try_cnt_d = try_cnt_q + 8'd1;
                    state_d   = CHECK;
                end
            end
            CHECK: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!occ_grid[cand_q[6:0]]) begin
                    state_d      = GRANT;
                    ack_d        = owner_onehot;
                    cell_d       = cand_q;
                    last_grant_d = owner_q;
                end else if (try_cnt_q == 8'(MAX_TRIES)) begin
`ifdef SPAWN_SCAN_FALLBACK_EN
                    state_d    = SCAN;
                    scan_idx_d = '0;
`else
                    state_d      = FAIL;
                    ack_d        = owner_onehot;
                    fail_d       = 1'b1;
                    last_grant_d = owner_q;
`endif
                end else begin
                    state_d = DRAW;
                end
            end
`ifdef SPAWN_SCAN_FALLBACK_EN
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!occ_grid[scan_cell[6:0]]) begin
                    state_d      = GRANT;
                    ack_d        = owner_onehot;
                    cell_d       = scan_cell;
                    last_grant_d = owner_q;
                end else if (scan_idx_q == 6'd63) begin
                    state_d      = FAIL;
                    ack_d        = owner_onehot;
                    fail_d       = 1'b1;
                    last_grant_d = owner_q;
                end else begin
                    scan_idx_d = scan_idx_q + 6'd1;
                end
            end
`endif
            // ack/fail were registered on entry, so these states only last one cycle.
            GRANT, FAIL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_25M or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            try_cnt_q    <= '0;
            cand_q       <= '0;
            cell_q       <= '0;
            ack_q        <= 2'b00;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            try_cnt_q    <= try_cnt_d;
            cand_q       <= cand_d;
            cell_q       <= cell_d;
            ack_q        <= ack_d;
            fail_q       <= fail_d;
        end
    end

    assign ack      = ack_q;
    assign cell_out = cell_q;
    assign fail     = fail_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_spawn_arbiter.sv
// tb_spawn_arbiter: directed checks of spawn_arbiter (MAX_TRIES=4) plus a SEED=0 instance;
// expectations follow SPAWN_SCAN_FALLBACK_EN when the bench is built with it.
module tb_spawn_arbiter;

    logic         clk_25M;
    logic         rst;
    logic [1:0]   req;
    logic [100:0] occ;
    logic [1:0]   ack;
    logic [7:0]   cell_out;
    logic         fail;
    logic         busy;
    logic [1:0]   req0;
    logic [1:0]   ack0;
    logic [7:0]   cell0;
    logic         fail0;
    logic         busy0;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr;
    logic [15:0] hist [0:255];

    spawn_arbiter #(.MAX_TRIES(4), .SEED(16'hACE1)) dut (
        .clk_25M  (clk_25M),
        .rst      (rst),
        .req      (req),
        .occ_grid (occ),
        .ack      (ack),
        .cell_out (cell_out),
        .fail     (fail),
        .busy     (busy)
    );

    spawn_arbiter #(.MAX_TRIES(4), .SEED(16'h0000)) dut0 (
        .clk_25M  (clk_25M),
        .rst      (rst),
        .req      (req0),
        .occ_grid (occ),
        .ack      (ack0),
        .cell_out (cell0),
        .fail     (fail0),
        .busy     (busy0)
    );

    initial clk_25M = 1'b0;
    always #20 clk_25M = ~clk_25M;

    // Reference LFSR: feedback is the parity of bits 15,13,12,10.
    always @(posedge clk_25M or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    end

    function automatic logic [7:0] tcand(input logic [15:0] v);
        int r;
        int c;
        r = int'(v[2:0]) + 1;
        c = int'(v[5:3]) + 2;
        return 8'(r * 10 + c);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_25M);
        #1;
    endtask

    // Counts edges until ack appears; n stays -1 if the budget runs out.
    task automatic wait_ack(input int budget, output int n, output logic [1:0] a, output logic f);
        n = -1;
        a = 2'b00;
        f = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            step();
            hist[i] = m_lfsr;
            if (ack !== 2'b00) begin
                n = i;
                a = ack;
                f = fail;
                break;
            end
        end
    endtask

    task automatic settle();
        req = 2'b00;
        step();
        chk("ack_one_cycle", {30'd0, ack}, 32'd0);
        chk("fail_one_cycle", {31'd0, fail}, 32'd0);
    endtask

    initial begin
        int         n;
        logic [1:0] a;
        logic       f;
        logic [7:0] exp_cell;
        logic [7:0] c1;
        int         kh;
        int         exp_n;
        logic       exp_f;
        logic [1:0] seen;

        rst  = 1'b1;
        req  = 2'b00;
        req0 = 2'b00;
        occ  = '0;
        repeat (2) step();

        // Reset state
        chk("rst_ack", {30'd0, ack}, 32'd0);
        chk("rst_cell", {24'd0, cell_out}, 32'd0);
        chk("rst_fail_busy", {30'd0, fail, busy}, 32'd0);
        chk("rst_lfsr", {16'd0, dut.u_lfsr.lfsr_q}, 32'hACE1);
        chk("seed0_lfsr", {16'd0, dut0.u_lfsr.lfsr_q}, 32'hACE1);
        chk("seed0_outs", {21'd0, ack0, fail0, busy0, cell0}, 32'd0);
        rst = 1'b0;

        // Contention from reset: apple first, then barrier
        occ = '0;
        req = 2'b11;
        wait_ack(20, n, a, f);
        c1 = tcand(hist[1]);
        chk("c11_first_lat", n, 3);
        chk("c11_first_ack", {30'd0, a}, 32'd1);
        chk("c11_first_fail", {31'd0, f}, 32'd0);
        chk("c11_first_cell", {24'd0, cell_out}, {24'd0, c1});
        req = 2'b10;
        wait_ack(20, n, a, f);
        exp_cell = tcand(hist[2]);
        chk("c11_second_lat", n, 4);
        chk("c11_second_ack", {30'd0, a}, 32'd2);
        chk("c11_second_cell", {24'd0, cell_out}, {24'd0, exp_cell});
        settle();

        // Single apple request, free grid
        req = 2'b01;
        wait_ack(20, n, a, f);
        exp_cell = tcand(hist[1]);
        chk("apple_lat", n, 3);
        chk("apple_ack", {30'd0, a}, 32'd1);
        chk("apple_fail", {31'd0, f}, 32'd0);
        chk("apple_cell", {24'd0, cell_out}, {24'd0, exp_cell});
        chk("apple_row_ok", {31'd0, (cell_out / 10 >= 1) && (cell_out / 10 <= 8)}, 32'd1);
        chk("apple_col_ok", {31'd0, (cell_out % 10 >= 2) && (cell_out % 10 <= 9)}, 32'd1);
        settle();

        // Contention after an apple grant: barrier goes first
        req = 2'b11;
        wait_ack(20, n, a, f);
        chk("fair_first_lat", n, 3);
        chk("fair_first_ack", {30'd0, a}, 32'd2);
        chk("fair_first_cell", {24'd0, cell_out}, {24'd0, tcand(hist[1])});
        req = 2'b01;
        wait_ack(20, n, a, f);
        exp_cell = tcand(hist[2]);
        chk("fair_second_ack", {30'd0, a}, 32'd1);
        chk("fair_second_cell", {24'd0, cell_out}, {24'd0, exp_cell});
        settle();

        // Only cell 57 free (everything else, in or out of the region, occupied)
        occ = '1;
        occ[57] = 1'b0;
        req = 2'b01;
        wait_ack(200, n, a, f);
        kh = 0;
        for (int k = 1; k <= 4; k++)
            if (kh == 0 && tcand(hist[2 * k - 1]) == 8'd57) kh = k;
`ifdef SPAWN_SCAN_FALLBACK_EN
        exp_n    = (kh != 0) ? 2 * kh + 1 : 47;
        exp_f    = 1'b0;
        exp_cell = 8'd57;
`else
        exp_n = (kh != 0) ? 2 * kh + 1 : 9;
        exp_f = (kh == 0);
        if (kh != 0) exp_cell = 8'd57;
`endif
        chk("one_free_lat", n, exp_n);
        chk("one_free_ack", {30'd0, a}, 32'd1);
        chk("one_free_fail", {31'd0, f}, {31'd0, exp_f});
        chk("one_free_cell", {24'd0, cell_out}, {24'd0, exp_cell});
        settle();

        // All cells occupied: fail, cell_out held
        occ = '1;
        req = 2'b01;
        wait_ack(200, n, a, f);
`ifdef SPAWN_SCAN_FALLBACK_EN
        exp_n = 73;
`else
        exp_n = 9;
`endif
        chk("full_lat", n, exp_n);
        chk("full_ack", {30'd0, a}, 32'd1);
        chk("full_fail", {31'd0, f}, 32'd1);
        chk("full_cell_held", {24'd0, cell_out}, {24'd0, exp_cell});
        settle();

        // Barrier request dropped mid-search: no ack, back to idle
        req  = 2'b10;
        seen = 2'b00;
`ifdef SPAWN_SCAN_FALLBACK_EN
        repeat (12) begin step(); seen |= ack; end
`else
        repeat (3) begin step(); seen |= ack; end
`endif
        req = 2'b00;
        step();
        seen |= ack;
        chk("abort_noack", {30'd0, seen}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        req = 2'b10;
        wait_ack(200, n, a, f);
        chk("restart_lat", n, exp_n);
        chk("restart_ack", {30'd0, a}, 32'd2);
        chk("restart_fail", {31'd0, f}, 32'd1);
        settle();

        // Reset asserted while in DRAW
        occ = '0;
        req = 2'b01;
        step();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ack", {30'd0, ack}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_cell", {24'd0, cell_out}, 32'd0);
        chk("mid_rst_lfsr", {16'd0, dut.u_lfsr.lfsr_q}, 32'hACE1);
        chk("mid_rst_seed0", {16'd0, dut0.u_lfsr.lfsr_q}, 32'hACE1);
        req = 2'b00;
        step();
        rst = 1'b0;
        step();
        chk("post_rst_ack", {30'd0, ack}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
